// File: rtl/fifo_adapter_wr_arbiter_pkg.sv
// Shared types and sizing for the FIFO adapter write arbiter.
// The adapter and its benches reuse the default geometry from here.
package fifo_adapter_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        BURST = 2'b10
    } state_e;

    localparam int DEF_DATA_IN_WIDTH  = 16;
    localparam int DEF_DATA_OUT_WIDTH = 128;
    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_BURST_LEN      = 64;

    localparam int RATIO       = DEF_DATA_OUT_WIDTH / DEF_DATA_IN_WIDTH;
    localparam int BURST_WORDS = DEF_BURST_LEN / RATIO;
    localparam int DEPTH       = 2 ** DEF_ADDR_WIDTH;

    function automatic int words_of(int beats, int in_w, int out_w);
        return beats / (out_w / in_w);
    endfunction

endpackage

// File: rtl/fifo_adapter_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr,
// wrapping at N. ptr itself has the lowest priority.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = ($clog2(N))'((int'(ptr) + i) % N);
                onehot[(int'(ptr) + i) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_adapter_wr_arbiter.sv
// Round-robin burst arbiter sharing one narrow-to-wide FIFO adapter
// between NUM_REQ producers; one grant = one whole burst.
module fifo_adapter_wr_arbiter
    import fifo_adapter_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
    parameter int DATA_OUT_WIDTH = DEF_DATA_OUT_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int PIPE_SLACK     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_pend_i,
    input  logic [NUM_REQ-1:0]               req_vld_i,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0] req_dat_i,
    output logic [NUM_REQ-1:0]               req_rdy_o,
    output logic                             wr_ena_o,
    output logic [DATA_IN_WIDTH-1:0]         wr_dat_o,
    input  logic                             wr_full_i,
    input  logic [ADDR_WIDTH:0]              fifo_cnt_i,
    output logic [NUM_REQ-1:0]               grant_o,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id_o,
    output logic                             busy_o
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int BCW = $clog2(BURST_LEN);
    localparam int BW  = words_of(BURST_LEN, DATA_IN_WIDTH, DATA_OUT_WIDTH);

    localparam logic [ADDR_WIDTH:0] DEP  = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] NEED = (ADDR_WIDTH+1)'(BW + PIPE_SLACK);
    localparam logic [BCW-1:0]      LAST = BCW'(BURST_LEN - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [BCW-1:0]       beat_q, beat_d;

    logic [ADDR_WIDTH:0]  free;
    logic                 space_ok;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;

    assign free     = DEP - fifo_cnt_i;
    assign space_ok = (free >= NEED);

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req    (req_pend_i),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

    // The last owner doubles as the round-robin pointer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        req_rdy_o = '0;
        wr_ena_o  = 1'b0;
        wr_dat_o  = '0;
        unique case (state_q)
            IDLE: begin
                if (space_ok && pick_any) begin
                    state_d = BURST;
                    grant_d = pick_oh;
                    ptr_d   = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                wr_dat_o = req_dat_i[int'(ptr_q)*DATA_IN_WIDTH +: DATA_IN_WIDTH];
                req_rdy_o[ptr_q] = ~wr_full_i & ~rst;
                wr_ena_o = req_vld_i[ptr_q] & ~wr_full_i & ~rst;
                if (wr_ena_o) begin
                    if (beat_q == LAST) begin
                        state_d = IDLE;
                        grant_d = '0;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                beat_d  = '0;
            end
        endcase
    end

    assign grant_o    = grant_q;
    assign grant_id_o = ptr_q;
    assign busy_o     = (state_q == BURST);

endmodule

// File: tb/tb_fifo_adapter_wr_arbiter.sv
// Directed scenarios with random beat data, checked against a
// transaction-level model of owner, burst length and source order.
module tb_fifo_adapter_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int BL  = 64;
    localparam int MEM = 2048;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    pend = '0;
    logic [N-1:0]    vld = '0;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    req_rdy;
    logic            wr_ena;
    logic [DW-1:0]   wr_dat;
    logic            full = 1'b0;
    logic [AW:0]     fcnt = '0;
    logic [N-1:0]    grant;
    logic [1:0]      gid;
    logic            busy;

    logic [DW-1:0] src [N][MEM];
    int rp [N];
    int mp [N];
    int owner, last, mcnt;
    int n_chk, n_fail;
    int bbeats, total;
    logic [N-1:0] pg;
    int glog [$];
    int blog [$];

    always #5 clk = ~clk;

    fifo_adapter_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_pend_i (pend),
        .req_vld_i  (vld),
        .req_dat_i  (req_dat),
        .req_rdy_o  (req_rdy),
        .wr_ena_o   (wr_ena),
        .wr_dat_o   (wr_dat),
        .wr_full_i  (full),
        .fifo_cnt_i (fcnt),
        .grant_o    (grant),
        .grant_id_o (gid),
        .busy_o     (busy)
    );

    always_comb begin
        req_dat = '0;
        for (int i = 0; i < N; i++)
            req_dat[i*DW +: DW] = src[i][rp[i]];
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [N-1:0]  e_rdy;
        logic          e_ena;
        logic [DW-1:0] e_dat;
        logic [N-1:0]  hs;
        bit            found;
        @(negedge clk);
        #1;
        e_rdy = '0;
        e_ena = 1'b0;
        e_dat = '0;
        if (owner >= 0) begin
            e_dat = src[owner][mp[owner]];
            if (!rst && !full) begin
                e_rdy = N'(1 << owner);
                e_ena = vld[owner];
            end
        end
        chk("grant", 32'(grant), owner >= 0 ? 32'(1 << owner) : 32'd0);
        chk("grant_id", 32'(gid), 32'(last));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
        chk("wr_ena", 32'(wr_ena), 32'(e_ena));
        chk("wr_dat", 32'(wr_dat), 32'(e_dat));
        if (grant != 0 && pg == 0) begin
            glog.push_back(int'(gid));
            bbeats = 0;
        end
        if (grant == 0 && pg != 0) blog.push_back(bbeats);
        pg = grant;
        if (wr_ena) begin
            bbeats++;
            total++;
        end
        hs = req_rdy & vld;
        if (rst) begin
            owner = -1;
            last  = N - 1;
        end else if (owner >= 0) begin
            if (e_ena) begin
                mp[owner]++;
                mcnt++;
                if (mcnt == BL) owner = -1;
            end
        end else if ((1 << AW) - int'(fcnt) >= BL / 8 + 2 && pend != 0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && pend[(last + k) % N]) begin
                    found = 1;
                    owner = (last + k) % N;
                end
            end
            last = owner;
            mcnt = 0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i]) rp[i]++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rst_pulse();
        pend = '0;
        vld  = '0;
        full = 1'b0;
        fcnt = '0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        total  = 0;
        bbeats = 0;
    endtask

    task automatic until_beats(int n, string tag);
        for (int k = 0; k < 200 && bbeats < n; k++) tick();
        chk(tag, 32'(bbeats), 32'(n));
    endtask

    initial begin
        int v;
        n_chk = 0;
        n_fail = 0;
        owner = -1;
        last = N - 1;
        mcnt = 0;
        pg = '0;
        for (int i = 0; i < N; i++) begin
            rp[i] = 0;
            mp[i] = 0;
            for (int j = 0; j < MEM; j++) src[i][j] = DW'($urandom);
        end

        // reset state
        rst_pulse();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_gid", 32'(gid), 3);
        chk("rst_busy", 32'(busy), 0);

        // single requester, full burst
        pend = 4'b0001;
        vld  = 4'b0001;
        tick();
        pend = '0;
        chk("s1_grant", 32'(grant), 1);
        run(80);
        chk("s1_beats", 32'(total), 64);
        chk("s1_idle", 32'(grant), 0);
        chk("s1_busy", 32'(busy), 0);

        // all pending, random valid gaps, rotation order
        rst_pulse();
        glog.delete();
        blog.delete();
        pend = 4'b1111;
        for (int k = 0; k < 600 && glog.size() < 5; k++) begin
            for (int i = 0; i < N; i++) vld[i] = ($urandom_range(0, 7) != 0);
            tick();
        end
        pend = '0;
        vld  = 4'b1111;
        run(80);
        chk("s2_ngrants", 32'(glog.size()), 5);
        for (int i = 0; i < 5; i++) begin
            v = (i < glog.size()) ? glog[i] : 99;
            chk("s2_order", 32'(v), 32'(i % N));
        end
        for (int i = 0; i < 5; i++) begin
            v = (i < blog.size()) ? blog[i] : 0;
            chk("s2_burst_len", 32'(v), 64);
        end

        // space threshold
        rst_pulse();
        fcnt = 9'd247;
        pend = 4'b0010;
        vld  = 4'b0010;
        run(5);
        chk("s3_nogrant", 32'(grant), 0);
        fcnt = 9'd246;
        tick();
        chk("s3_grant", 32'(grant), 32'b0010);
        pend = '0;
        run(80);
        chk("s3_beats", 32'(total), 64);

        // wr_full stall at beat 30
        rst_pulse();
        pend = 4'b0001;
        vld  = 4'b0001;
        tick();
        pend = '0;
        until_beats(30, "s4_at30");
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("s4_rdy", 32'(req_rdy), 0);
            chk("s4_ena", 32'(wr_ena), 0);
        end
        chk("s4_held", 32'(bbeats), 30);
        full = 1'b0;
        run(80);
        chk("s4_beats", 32'(total), 64);

        // valid gap mid-burst
        rst_pulse();
        pend = 4'b0100;
        vld  = 4'b0100;
        tick();
        pend = '0;
        until_beats(20, "s5_at20");
        vld = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("s5_grant", 32'(grant), 32'b0100);
        end
        chk("s5_held", 32'(bbeats), 20);
        vld = 4'b0100;
        run(80);
        chk("s5_beats", 32'(total), 64);

        // reset mid-burst
        rst_pulse();
        pend = 4'b0010;
        vld  = 4'b0010;
        tick();
        pend = '0;
        until_beats(20, "s6_at20");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_grant", 32'(grant), 0);
        chk("s6_ena", 32'(wr_ena), 0);
        chk("s6_busy", 32'(busy), 0);
        chk("s6_gid", 32'(gid), 3);
        pend = 4'b0011;
        vld  = 4'b0011;
        tick();
        pend = '0;
        chk("s6_regrant", 32'(grant), 32'b0001);
        run(80);
        chk("s6_beats", 32'(bbeats), 64);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
